exec_seq: RTL
=============

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 Parameter SETUP_CYCLES, default 1, cycles spent in SETUP before the operand phase; legal range >=1.
REQ-002 Parameter WRITE_CYCLES, default 3, cycles reg_dest_en is held in WRITE before PCINC; legal range >=1.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum MEMWAIT cycles before a LOAD errors; legal range >=1.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request to execute one instruction; accepted only in IDLE.
REQ-007 opcode  in  2  00 NOP, 01 MOVI, 10 MOV, 11 LOAD; sampled only on start acceptance.
REQ-008 mem_ready  in  1  memory read data valid; observed only in MEMWAIT.
REQ-009 abort  in  1  cancel current instruction.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 reg_dest_en  out  1  destination register write enable.
REQ-012 imm_out_en  out  1  immediate storage drives data bus (MOVI).
REQ-013 src_out_en  out  1  source register drives data bus (MOV).
REQ-014 mem_rd  out  1  memory read strobe (LOAD).
REQ-015 pc_inc  out  1  program counter increment, one-cycle pulse.
REQ-016 done  out  1  instruction complete, one-cycle pulse.
REQ-017 err  out  1  LOAD timeout, one-cycle pulse coincident with done.

Function
REQ-018 States: IDLE, SETUP, MEMWAIT, WRITE, PCINC, DONE, ERR; outputs are Moore, decoded from the state register and latched opcode only.
REQ-019 IDLE: all outputs 0; start=1 latches opcode and enters SETUP next cycle.
REQ-020 SETUP: exactly SETUP_CYCLES cycles, only busy high; then LOAD->MEMWAIT, MOVI/MOV->WRITE, NOP->PCINC.
REQ-021 MEMWAIT: mem_rd=1; mem_ready=1 -> WRITE next cycle; mem_ready still 0 on the MEM_TIMEOUT-th MEMWAIT cycle -> ERR; mem_ready=1 on that cycle wins.
REQ-022 WRITE: exactly WRITE_CYCLES cycles; reg_dest_en=1 plus opcode source enable (imm_out_en MOVI, src_out_en MOV, mem_rd LOAD); then PCINC.
REQ-023 PCINC: one cycle; pc_inc=1; reg_dest_en and source enable stay high except for NOP (pc_inc only); then DONE.
REQ-024 DONE: one cycle; done=1, all other strobes 0, busy=1; then IDLE.
REQ-025 ERR: one cycle; done=1, err=1, no reg_dest_en, no pc_inc; then IDLE.
REQ-026 At most one source enable high in any cycle; source enable never high without reg_dest_en except mem_rd in MEMWAIT.
REQ-027 Start-to-done latency (start-accept edge to done-high cycle): MOVI/MOV = SETUP_CYCLES+WRITE_CYCLES+2; NOP = SETUP_CYCLES+2; LOAD = that of MOVI plus MEMWAIT cycles.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, no done/pc_inc; abort has priority over all transitions; ignored in IDLE.
REQ-029 start and opcode ignored outside IDLE; start held high through DONE is accepted in the following IDLE cycle.
REQ-030 Phase counter width $clog2(max(SETUP_CYCLES,WRITE_CYCLES,MEM_TIMEOUT)+1); reloaded on every state entry; no wrap.
REQ-031 Unused state encodings -> IDLE next cycle.

Reset
REQ-032 reset=0 at a clk edge forces IDLE, clears counter and latched opcode, all outputs 0 next cycle, overriding start/abort, mid-instruction included.

Structure
REQ-033 Package exec_seq_pkg holds opcode codes and state encodings, shared with the decoder.
REQ-034 One sub-module exec_seq_cnt: loadable down-counter with zero flag, width parameter.

Verification
REQ-035 Defaults, MOVI start at cycle 0 -> SETUP c1, reg_dest_en+imm_out_en c2-c5, pc_inc c5, done c6, busy low c7.
REQ-036 LOAD, mem_ready high on 3rd MEMWAIT cycle -> mem_rd c2-c4, then c5-c8 with reg_dest_en, pc_inc c8, done c9, err 0.
REQ-037 LOAD, mem_ready held 0 -> 15 MEMWAIT cycles, ERR with done=err=1 at c17, no reg_dest_en/pc_inc ever.
REQ-038 NOP -> pc_inc c2 only, done c3; abort in WRITE c3 of MOVI -> all outputs 0 c4, no done.
REQ-039 reset=0 at c3 of MOVI -> all outputs 0 c4; start held through DONE -> back-to-back instruction, SETUP immediately after one IDLE cycle.
REQ-040 SETUP_CYCLES=2, WRITE_CYCLES=1, MOV -> src_out_en+reg_dest_en c3-c4, pc_inc c4, done c5.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared opcode and state encodings for the instruction execution sequencer.
// The same encodings are used by the instruction decoder.
package exec_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_MOVI = 2'b01,
        OP_MOV  = 2'b10,
        OP_LOAD = 2'b11
    } opcode_e;

    // Encoding 3'd7 is unused and recovers to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_PCINC   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/exec_seq_cnt.sv
// Loadable down-counter with a zero flag. Load has priority over the count,
// and the count holds at zero instead of wrapping.
module exec_seq_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/exec_seq.sv
// Multi-cycle instruction execution sequencer for NOP/MOVI/MOV/LOAD.
// All strobes are Moore outputs decoded from the state and the latched opcode.
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int WRITE_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] opcode,
    input  logic       mem_ready,
    input  logic       abort,
    output logic       busy,
    output logic       reg_dest_en,
    output logic       imm_out_en,
    output logic       src_out_en,
    output logic       mem_rd,
    output logic       pc_inc,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, WRITE_CYCLES, MEM_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The counter is loaded with N-1 so the zero flag marks the last cycle of a phase.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LOAD   = CW'(MEM_TIMEOUT - 1);

    state_e          state_reg, state_next;
    opcode_e         opcode_reg, opcode_next;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= OP_NOP;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    opcode_next = opcode_e'(opcode);
                    state_next  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    case (opcode_reg)
                        OP_LOAD: state_next = ST_MEMWAIT;
                        OP_NOP:  state_next = ST_PCINC;
                        default: state_next = ST_WRITE;
                    endcase
                end
            end
            ST_MEMWAIT: begin
                // Data arriving on the final allowed cycle still beats the timeout.
                if (mem_ready) begin
                    state_next = ST_WRITE;
                end else if (cnt_zero) begin
                    state_next = ST_ERR;
                end
            end
            ST_WRITE: begin
                if (cnt_zero) begin
                    state_next = ST_PCINC;
                end
            end
            ST_PCINC: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        cnt_load     = (state_next != state_reg);
        cnt_load_val = '0;
        case (state_next)
            ST_SETUP:   cnt_load_val = SETUP_LOAD;
            ST_MEMWAIT: cnt_load_val = MEM_LOAD;
            ST_WRITE:   cnt_load_val = WRITE_LOAD;
            default:    cnt_load_val = '0;
        endcase
    end

    exec_seq_cnt #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        busy        = 1'b0;
        reg_dest_en = 1'b0;
        imm_out_en  = 1'b0;
        src_out_en  = 1'b0;
        mem_rd      = 1'b0;
        pc_inc      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_reg)
            ST_SETUP: busy = 1'b1;
            ST_MEMWAIT: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
            end
            ST_WRITE, ST_PCINC: begin
                busy   = 1'b1;
                pc_inc = (state_reg == ST_PCINC);
                if (opcode_reg != OP_NOP) begin
                    reg_dest_en = 1'b1;
                    imm_out_en  = (opcode_reg == OP_MOVI);
                    src_out_en  = (opcode_reg == OP_MOV);
                    mem_rd      = (opcode_reg == OP_LOAD);
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ST_ERR: begin
                busy = 1'b1;
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
